conv3d_writeback: RTL and testbench

CONV3D_WRITEBACK -- requirements
Module: conv3d_writeback

---
 rtl/conv3d_writeback_if.sv | 30 +++
 rtl/conv3d_writeback.sv | 101 ++++++++++
 tb/tb_conv3d_writeback.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3d_writeback_if.sv
// rtl/conv3d_writeback_if.sv - job, result-stream and memory-write signals of conv3d_writeback
interface conv3d_writeback_if #(
    parameter int AW = 128,
    parameter int DW = 128
);
    logic          param_ena;
    logic [AW-1:0] param_zaddr;
    logic [17:0]   param_length_out;
    logic          din_valid;
    logic [DW-1:0] din_data;
    logic          din_ready;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_ack;
    logic          flag_write_over;
    logic          busy;
    logic          err_cfg;

    modport master (
        output param_ena, param_zaddr, param_length_out, din_valid, din_data, wr_ready, wr_ack,
        input  din_ready, wr_valid, wr_addr, wr_data, flag_write_over, busy, err_cfg
    );

    modport slave (
        input  param_ena, param_zaddr, param_length_out, din_valid, din_data, wr_ready, wr_ack,
        output din_ready, wr_valid, wr_addr, wr_data, flag_write_over, busy, err_cfg
    );
endinterface

// File: rtl/conv3d_writeback.sv
// rtl/conv3d_writeback.sv - writes conv result words to sequential addresses and pulses when all acks return
module conv3d_writeback #(
    parameter int AW = 128,
    parameter int DW = 128
) (
    input logic clk,
    input logic rst,
    conv3d_writeback_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [17:0]   len_q;
    logic [17:0]   issue_cnt;
    logic [17:0]   ack_cnt;
    logic          wr_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          err_q;

    logic          din_hs;
    logic          wr_hs;
    logic          ack_inc;
    logic [17:0]   ack_nxt;
    logic          active;

    assign active  = (state == RUN) || (state == DRAIN);
    assign bus.din_ready = (state == RUN) && (issue_cnt < len_q) && (!wr_valid_q || bus.wr_ready);
    assign din_hs  = bus.din_valid && bus.din_ready;
    assign wr_hs   = wr_valid_q && bus.wr_ready;
    // Saturate rather than wrap; a stray extra ack must not alias back to zero.
    assign ack_inc = bus.wr_ack && active && (ack_cnt != 18'h3ffff);
    assign ack_nxt = ack_cnt + {17'd0, ack_inc};

    assign bus.wr_valid        = wr_valid_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.busy            = (state != IDLE);
    assign bus.flag_write_over = (state == DONE);
    assign bus.err_cfg         = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            ack_cnt    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            // A new word may replace the accepted one in the same cycle for full throughput.
            if (din_hs) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= addr_q + AW'(issue_cnt);
                wr_data_q  <= bus.din_data;
                issue_cnt  <= issue_cnt + 18'd1;
            end else if (wr_hs) begin
                wr_valid_q <= 1'b0;
            end

            if (ack_inc) begin
                ack_cnt <= ack_nxt;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.param_ena) begin
                        addr_q    <= bus.param_zaddr;
                        len_q     <= bus.param_length_out;
                        issue_cnt <= '0;
                        ack_cnt   <= '0;
                        state     <= (bus.param_length_out == 18'd0) ? DONE : RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.param_ena) begin
                        err_q <= 1'b1;
                    end
                    if (wr_hs && (issue_cnt == len_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.param_ena) begin
                        err_q <= 1'b1;
                    end
                    if (ack_nxt == len_q) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3d_writeback.sv
// tb/tb_conv3d_writeback.sv - directed bench for conv3d_writeback with ack responder and write monitor
module tb_conv3d_writeback;
    localparam int AW = 128;
    localparam int DW = 128;
    localparam int ACK_DLY = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv3d_writeback_if #(.AW(AW), .DW(DW)) bus ();
    conv3d_writeback #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int wr_cyc_q[$];
    int din_cyc_q[$];
    int ack_cyc_q[$];
    int flag_cyc_q[$];
    int ack_due[$];
    int ack_rd = 0;
    int valid_cycles = 0;
    int stall_cycles = 0;
    int stall_bad = 0;
    logic stall_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    int start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.din_valid && bus.din_ready) din_cyc_q.push_back(cyc);
        if (bus.wr_valid && bus.wr_ready) begin
            wr_addr_q.push_back(bus.wr_addr);
            wr_data_q.push_back(bus.wr_data);
            wr_cyc_q.push_back(cyc);
            ack_due.push_back(cyc + ACK_DLY);
        end
        if (bus.wr_ack) ack_cyc_q.push_back(cyc);
        if (bus.flag_write_over) flag_cyc_q.push_back(cyc);
        if (bus.wr_valid) valid_cycles <= valid_cycles + 1;
        if (bus.wr_valid && !bus.wr_ready) stall_cycles <= stall_cycles + 1;
        if ((bus.wr_valid && !bus.wr_ready && bus.din_ready) ||
            (stall_prev && (bus.wr_valid !== 1'b1 || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data)))
            stall_bad <= stall_bad + 1;
        stall_prev <= bus.wr_valid && !bus.wr_ready;
        prev_addr  <= bus.wr_addr;
        prev_data  <= bus.wr_data;
    end

    // Memory side: one ack pulse ACK_DLY cycles after each accepted request.
    initial begin
        bus.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_rd < ack_due.size() && ack_due[ack_rd] == cyc) begin
                bus.wr_ack = 1'b1;
                ack_rd++;
            end else begin
                bus.wr_ack = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_din_ready"}, 128'(bus.din_ready), 128'd0);
        check({tag, "_wr_valid"}, 128'(bus.wr_valid), 128'd0);
        check({tag, "_wr_addr"}, 128'(bus.wr_addr), 128'd0);
        check({tag, "_wr_data"}, 128'(bus.wr_data), 128'd0);
        check({tag, "_flag"}, 128'(bus.flag_write_over), 128'd0);
        check({tag, "_busy"}, 128'(bus.busy), 128'd0);
        check({tag, "_err_cfg"}, 128'(bus.err_cfg), 128'd0);
    endtask

    task automatic start_job(input logic [AW-1:0] zaddr, input logic [17:0] len);
        bus.param_ena = 1'b1;
        bus.param_zaddr = zaddr;
        bus.param_length_out = len;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bus.param_ena = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int ok = 0;
            bus.din_valid = 1'b1;
            bus.din_data = base + DW'(i);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.din_ready) begin
                    ok = 1;
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check("din_accept_timeout", 128'(ok), 128'd1);
            if (ok == 0) break;
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
        check("wait_done_timeout", 128'(ok), 128'd1);
    endtask

    task automatic check_job(input string tag, input int idx, input int n,
                             input logic [AW-1:0] a0, input logic [DW-1:0] d0);
        logic [AW-1:0] ea;
        check({tag, "_count"}, 128'(wr_addr_q.size() - idx), 128'(n));
        for (int i = 0; i < n && idx + i < wr_addr_q.size(); i++) begin
            ea = a0 + AW'(i);
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[idx + i], ea);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[idx + i], d0 + DW'(i));
        end
    endtask

    initial begin
        int nw, nf, na, nd, sc, sb, vc, ok;
        logic [AW-1:0] top;
        bus.param_ena = 1'b0;
        bus.param_zaddr = '0;
        bus.param_length_out = '0;
        bus.din_valid = 1'b0;
        bus.din_data = '0;
        bus.wr_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Four words back-to-back, acks two cycles after each request.
        nw = wr_addr_q.size(); nf = flag_cyc_q.size(); na = ack_cyc_q.size(); nd = din_cyc_q.size();
        start_job(128'h100, 18'd4);
        send_words(4, 128'hA0);
        wait_done(50);
        check_job("job4", nw, 4, 128'h100, 128'hA0);
        for (int i = 1; i < 4 && nw + i < wr_cyc_q.size(); i++)
            check($sformatf("job4_consec%0d", i), 128'(wr_cyc_q[nw + i] - wr_cyc_q[nw]), 128'(i));
        check("job4_first_din_cyc", 128'(din_cyc_q[nd] - start_cyc), 128'd1);
        check("job4_first_wr_lat", 128'(wr_cyc_q[nw] - din_cyc_q[nd]), 128'd1);
        check("job4_acks", 128'(ack_cyc_q.size() - na), 128'd4);
        check("job4_flags", 128'(flag_cyc_q.size() - nf), 128'd1);
        check("job4_flag_cyc", 128'(flag_cyc_q[nf] - start_cyc), 128'd8);
        check("job4_flag_after_ack", 128'(flag_cyc_q[nf] - ack_cyc_q[ack_cyc_q.size() - 1]), 128'd1);

        // Length 3 with the second request stalled for five cycles.
        nw = wr_addr_q.size(); nf = flag_cyc_q.size(); sc = stall_cycles; sb = stall_bad;
        start_job(128'h180, 18'd3);
        fork
            send_words(3, 128'hB0);
            begin
                ok = 0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (wr_addr_q.size() - nw >= 1) begin
                        ok = 1;
                        break;
                    end
                end
                bus.wr_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.wr_ready = 1'b1;
            end
        join
        wait_done(60);
        check("stall_wait_timeout", 128'(ok), 128'd1);
        check_job("stall", nw, 3, 128'h180, 128'hB0);
        check("stall_cycles", 128'(stall_cycles - sc), 128'd5);
        check("stall_hold_and_din_ready", 128'(stall_bad - sb), 128'd0);
        check("stall_flags", 128'(flag_cyc_q.size() - nf), 128'd1);
        check("stall_flag_after_ack", 128'(flag_cyc_q[nf] - ack_cyc_q[ack_cyc_q.size() - 1]), 128'd1);

        // Zero-length job completes immediately without requests.
        nf = flag_cyc_q.size(); vc = valid_cycles;
        start_job(128'h200, 18'd0);
        check("len0_flag_now", 128'(bus.flag_write_over), 128'd1);
        wait_done(10);
        check("len0_flags", 128'(flag_cyc_q.size() - nf), 128'd1);
        check("len0_flag_cyc", 128'(flag_cyc_q[nf] - start_cyc), 128'd1);
        check("len0_no_valid", 128'(valid_cycles - vc), 128'd0);

        // Address wraps modulo 2^AW.
        top = '1;
        nw = wr_addr_q.size();
        start_job(top - 1, 18'd3);
        send_words(3, 128'hC0);
        wait_done(50);
        check_job("wrap", nw, 3, top - 1, 128'hC0);
        check("wrap_last_zero", wr_addr_q[nw + 2], 128'd0);

        // Start during RUN is ignored and flagged; start in DONE chains the next job.
        nw = wr_addr_q.size(); nf = flag_cyc_q.size();
        start_job(128'h300, 18'd3);
        fork
            send_words(3, 128'hD0);
            begin
                @(posedge clk);
                #1;
                bus.param_ena = 1'b1;
                bus.param_zaddr = 128'h999;
                bus.param_length_out = 18'd7;
                @(posedge clk);
                #1;
                bus.param_ena = 1'b0;
            end
        join
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.flag_write_over) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("chain_flag_timeout", 128'(ok), 128'd1);
        check("chain_err_cfg", 128'(bus.err_cfg), 128'd1);
        check_job("chain_job1", nw, 3, 128'h300, 128'hD0);
        na = wr_addr_q.size();
        start_job(128'h400, 18'd2);
        check("chain_busy", 128'(bus.busy), 128'd1);
        check("chain_din_ready", 128'(bus.din_ready), 128'd1);
        send_words(2, 128'hE0);
        wait_done(50);
        check_job("chain_job2", na, 2, 128'h400, 128'hE0);
        check("chain_flags", 128'(flag_cyc_q.size() - nf), 128'd2);
        check("chain_err_sticky", 128'(bus.err_cfg), 128'd1);

        // Reset mid-job abandons it; late acks are ignored.
        nf = flag_cyc_q.size();
        start_job(128'h500, 18'd5);
        send_words(2, 128'hF0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_outputs_zero("midrst");
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_flag", 128'(flag_cyc_q.size() - nf), 128'd0);
        check("midrst_idle", 128'(bus.busy), 128'd0);
        nw = wr_addr_q.size(); nf = flag_cyc_q.size();
        start_job(128'h600, 18'd2);
        send_words(2, 128'h10);
        wait_done(50);
        check_job("after_rst", nw, 2, 128'h600, 128'h10);
        check("after_rst_flags", 128'(flag_cyc_q.size() - nf), 128'd1);
        check("after_rst_flag_after_ack", 128'(flag_cyc_q[nf] - ack_cyc_q[ack_cyc_q.size() - 1]), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
